dac_sample_scheduler: RTL and testbench

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

---
 rtl/dac_sample_scheduler.sv | 152 +++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// Sample scheduler for a delta-sigma DAC: buffers producer samples in a small FIFO,
// plays them at a programmable rate and ramps the output to/from mid-scale on start/stop.
//
// state     | meaning
// IDLE      | output parked at 0, FIFO flushed, producer stalled
// RAMP_UP   | dac_din climbs by RAMP_STEP per tick toward MID; FIFO may fill
// RUN       | one FIFO sample popped into dac_din per tick
// RAMP_DOWN | dac_din falls by RAMP_STEP per tick toward 0; FIFO contents kept
module dac_sample_scheduler #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int RAMP_STEP = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [15:0]              rate_div,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         dac_din,
    output logic                     underflow,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH:0]   MID_X    = (WIDTH+1)'(1) << (WIDTH-1);
    localparam logic [WIDTH-1:0] MID      = MID_X[WIDTH-1:0];
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(RAMP_STEP);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t            st;
    logic [15:0]       cnt;
    logic              tick;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic [WIDTH:0]    dac_x;
    logic [WIDTH:0]    up_sum;

    // A compare rather than equality lets a lowered rate_div fire on the very next cycle.
    assign tick    = (cnt >= rate_div);
    assign s_ready = ((st == RAMP_UP) || (st == RUN)) && (level < LVL_FULL);
    assign push    = s_valid && s_ready;
    assign pop     = (st == RUN) && enable && tick && (level != '0);
    assign dac_x   = {1'b0, dac_din};
    assign up_sum  = dac_x + STEP_X;
    assign state   = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            dac_din   <= '0;
            underflow <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end

            case (st)
                IDLE: begin
                    dac_din <= '0;
                    wr_ptr  <= '0;
                    rd_ptr  <= '0;
                    level   <= '0;
                    if (enable) begin
                        st        <= RAMP_UP;
                        underflow <= 1'b0;
                    end
                end
                RAMP_UP: begin
                    if (!enable) begin
                        st <= RAMP_DOWN;
                    end else if (tick) begin
                        if (up_sum >= MID_X) begin
                            dac_din <= MID;
                            st      <= RUN;
                        end else begin
                            dac_din <= up_sum[WIDTH-1:0];
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        st <= RAMP_DOWN;
                    end else if (tick) begin
                        if (level != '0) begin
                            dac_din <= mem[rd_ptr];
                        end else begin
                            underflow <= 1'b1;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (enable) begin
                        st <= RAMP_UP;
                    end else if (tick) begin
                        if (dac_x <= STEP_X) begin
                            // Reaching zero drops straight to IDLE with the FIFO already flushed.
                            dac_din <= '0;
                            st      <= IDLE;
                            wr_ptr  <= '0;
                            rd_ptr  <= '0;
                            level   <= '0;
                        end else begin
                            dac_din <= dac_din - STEP_X[WIDTH-1:0];
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: ramp, playback, back-pressure, stop/resume
// and reset corner cases, checked against hand-computed values and a small FIFO model.
module tb_dac_sample_scheduler;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] rate_div = 16'd0;
    logic [15:0] s_data = 16'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] dac_din;
    logic        underflow;
    logic [1:0]  state;
    logic [2:0]  level;

    dac_sample_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RAMP_STEP(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rate_div  (rate_div),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .dac_din   (dac_din),
        .underflow (underflow),
        .state     (state),
        .level     (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [15:0] dac;
        int          lvl;
        logic        uf;
    } vec_t;

    vec_t tbl[16];

    // FIFO/tick model used while in RUN with enable high
    int          mcnt;
    int          mlevel;
    int          maxlevel;
    logic [15:0] mdac;
    logic        muf;
    logic [15:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_cycle(input string tag, output bit acc);
        bit exp_ready;
        bit mtick;
        exp_ready = (mlevel < DEPTH);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'(exp_ready));
        acc   = s_valid && exp_ready;
        mtick = (mcnt >= int'(rate_div));
        if (mtick && mlevel == 0) muf = 1'b1;
        if (mtick && mlevel > 0) begin
            mdac = q.pop_front();
            mlevel--;
        end
        if (acc) begin
            q.push_back(s_data);
            mlevel++;
        end
        if (mlevel > maxlevel) maxlevel = mlevel;
        mcnt = mtick ? 0 : mcnt + 1;
        step();
        chk({tag, "_level"}, 32'(level), 32'(mlevel));
        chk({tag, "_dac"}, 32'(dac_din), 32'(mdac));
        chk({tag, "_uf"}, 32'(underflow), 32'(muf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;

        tbl[0]  = '{1'b1, 16'h1000, 16'h8000, 1, 1'b0};
        tbl[1]  = '{1'b1, 16'h2000, 16'h8000, 2, 1'b0};
        tbl[2]  = '{1'b1, 16'h3000, 16'h8000, 3, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 16'h1000, 2, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 16'h1000, 2, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 16'h1000, 2, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 16'h1000, 2, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 16'h2000, 1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 16'h2000, 1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 16'h2000, 1, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 16'h2000, 1, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 16'h3000, 0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 16'h3000, 0, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 16'h3000, 0, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 16'h3000, 0, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 16'h3000, 0, 1'b1};

        // reset values
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_dac", 32'(dac_din), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);

        // ramp up from 0 to MID with a tick every cycle
        rst_n    = 1'b1;
        enable   = 1'b1;
        rate_div = 16'd0;
        step();
        chk("start_state", 32'(state), 32'd1);
        chk("start_dac", 32'(dac_din), 32'd0);
        for (int i = 1; i <= 128; i++) begin
            step();
            chk("ramp_up_dac", 32'(dac_din), 32'(i * 256));
            chk("ramp_up_state", 32'(state), (i == 128) ? 32'd2 : 32'd1);
        end

        // RUN playback with rate_div=3, table driven
        rate_div = 16'd3;
        for (int i = 0; i < 16; i++) begin
            s_valid = tbl[i].v;
            s_data  = tbl[i].d;
            step();
            chk("play_dac", 32'(dac_din), 32'(tbl[i].dac));
            chk("play_level", 32'(level), 32'(tbl[i].lvl));
            chk("play_uf", 32'(underflow), 32'(tbl[i].uf));
        end

        // back-pressure: s_valid held high, rate_div=9
        mcnt     = 0;
        mlevel   = 0;
        maxlevel = 0;
        mdac     = 16'h3000;
        muf      = 1'b1;
        rate_div = 16'd9;
        s_valid  = 1'b1;
        s_data   = 16'h5000;
        for (int i = 0; i < 40; i++) begin
            model_cycle("bp", acc);
            if (acc) s_data = s_data + 16'h0010;
        end
        chk("bp_maxlevel", 32'(maxlevel), 32'd4);

        // drain at full rate, then push into an empty FIFO on a tick
        s_valid  = 1'b0;
        rate_div = 16'd0;
        for (int i = 0; i < 8; i++) model_cycle("drain", acc);
        s_valid = 1'b1;
        s_data  = 16'h0300;
        model_cycle("empty_push", acc);
        s_valid = 1'b0;
        model_cycle("pop_0300", acc);
        chk("at_0300", 32'(dac_din), 32'h0300);

        // stop: ramp down from 0x0300
        enable = 1'b0;
        step();
        chk("rd_state", 32'(state), 32'd3);
        chk("rd_dac0", 32'(dac_din), 32'h0300);
        chk("rd_s_ready", 32'(s_ready), 32'd0);
        step();
        chk("rd_dac1", 32'(dac_din), 32'h0200);
        step();
        chk("rd_dac2", 32'(dac_din), 32'h0100);
        step();
        chk("rd_dac3", 32'(dac_din), 32'h0000);
        chk("rd_idle", 32'(state), 32'd0);
        chk("rd_level", 32'(level), 32'd0);
        step();
        chk("idle_uf_sticky", 32'(underflow), 32'd1);
        chk("idle_dac", 32'(dac_din), 32'd0);

        // restart clears underflow; preload two samples during ramp
        enable = 1'b1;
        step();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_uf", 32'(underflow), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'hAAAA;
        step();
        s_data  = 16'hBBBB;
        step();
        s_valid = 1'b0;
        chk("preload_level", 32'(level), 32'd2);
        n = 0;
        while (dac_din !== 16'h6000 && n < 200) begin
            step();
            n++;
        end
        chk("ramp_to_6000", 32'(dac_din), 32'h6000);

        // ramp down to 0x4000 then resume
        enable = 1'b0;
        step();
        chk("rd2_state", 32'(state), 32'd3);
        chk("rd2_hold", 32'(dac_din), 32'h6000);
        for (int i = 1; i <= 32; i++) begin
            step();
            chk("rd2_dac", 32'(dac_din), 32'(16'h6000 - i * 256));
            chk("rd2_st", 32'(state), 32'd3);
        end
        enable = 1'b1;
        step();
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_dac", 32'(dac_din), 32'h4000);
        chk("resume_level", 32'(level), 32'd2);
        step();
        chk("resume_next", 32'(dac_din), 32'h4100);

        // reset in RUN
        n = 0;
        while (state !== 2'd2 && n < 100) begin
            step();
            n++;
        end
        chk("run_reached", 32'(state), 32'd2);
        chk("run_level", 32'(level), 32'd2);
        rst_n = 1'b0;
        step();
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_dac", 32'(dac_din), 32'd0);
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_uf", 32'(underflow), 32'd0);
        chk("rst2_s_ready", 32'(s_ready), 32'd0);

        // lowering rate_div mid-count ticks on the next cycle
        rst_n    = 1'b1;
        rate_div = 16'd100;
        step();
        chk("slow_state", 32'(state), 32'd1);
        repeat (10) step();
        chk("slow_hold", 32'(dac_din), 32'd0);
        rate_div = 16'd2;
        step();
        chk("fast_tick", 32'(dac_din), 32'd256);
        step();
        chk("fast_hold1", 32'(dac_din), 32'd256);
        step();
        chk("fast_hold2", 32'(dac_din), 32'd256);
        step();
        chk("fast_tick2", 32'(dac_din), 32'd512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
